// File: rtl/buzzer_seq.sv
// Multi-channel buzzer pattern sequencer: each channel steps through its own
// on/off slot pattern when triggered; channel levels merge onto one buzzer line.
module buzzer_seq #(
  parameter int NCH = 2,
  parameter int PLEN = 22,
  // 100 ms at a 50 MHz system clock
  parameter int SLOT_CMAX = 5_000_000,
  parameter logic [NCH*PLEN-1:0] PATS = {22'b0101010001010100010101, 22'd1},
  parameter logic [NCH*8-1:0] LENS = {8'd22, 8'd1},
  parameter int MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] tr,
  input  logic [NCH-1:0] stop,
  output logic           buz,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done
);

  localparam int TW = (SLOT_CMAX > 1) ? $clog2(SLOT_CMAX) : 1;
  localparam logic [TW-1:0] TMAX = TW'(SLOT_CMAX - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t        state [NCH];
  logic [7:0]    slot  [NCH];
  logic [TW-1:0] timer [NCH];
  logic [NCH-1:0] done_r;
  logic [NCH-1:0] lvl;

  // Priority per channel: rst, then tr (restart), then stop, then advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        slot[i]  <= 8'd0;
        timer[i] <= '0;
      end
      done_r <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        done_r[i] <= 1'b0;
        if (tr[i]) begin
          state[i] <= PLAY;
          slot[i]  <= 8'd0;
          timer[i] <= '0;
        end else if (state[i] == PLAY) begin
          if (stop[i]) begin
            state[i] <= IDLE;
            slot[i]  <= 8'd0;
            timer[i] <= '0;
          end else if (timer[i] == TMAX) begin
            timer[i] <= '0;
            if (slot[i] == LENS[i*8 +: 8] - 8'd1) begin
              state[i]  <= IDLE;
              slot[i]   <= 8'd0;
              done_r[i] <= 1'b1;
            end else begin
              slot[i] <= slot[i] + 8'd1;
            end
          end else begin
            timer[i] <= timer[i] + TW'(1);
          end
        end
      end
    end
  end

  // Levels come from registers only, so tr/stop never reach buz combinationally.
  always_comb begin
    busy = '0;
    lvl  = '0;
    for (int i = 0; i < NCH; i++) begin
      busy[i] = (state[i] == PLAY);
      lvl[i]  = busy[i] && PATS[i*PLEN + int'(slot[i])];
    end
  end

  always_comb begin
    buz = 1'b0;
    if (MODE == 0) begin
      buz = |lvl;
    end else begin
      // Walk from the top so the lowest-index busy channel wins.
      for (int i = NCH - 1; i >= 0; i--) begin
        if (busy[i]) buz = lvl[i];
      end
    end
  end

  assign done = done_r;

endmodule

// File: tb/tb_buzzer_seq.sv
// Directed bench for buzzer_seq: three instances (OR mode, priority mode,
// one-cycle slots) share stimulus; expected per-cycle words are queued, then popped.
module tb_buzzer_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] tr = 2'b00;
  logic [1:0] stop = 2'b00;

  logic       buz_a, buz_b, buz_c;
  logic [1:0] busy_a, busy_b, busy_c;
  logic [1:0] done_a, done_b, done_c;

  localparam logic [15:0] TB_PATS = {8'b00010101, 8'b00000010};
  localparam logic [15:0] TB_LENS = {8'd6, 8'd2};

  logic [4:0] exp_q[$];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  buzzer_seq #(.NCH(2), .PLEN(8), .SLOT_CMAX(3), .PATS(TB_PATS), .LENS(TB_LENS), .MODE(0))
    dut_a (.clk(clk), .rst(rst), .tr(tr), .stop(stop), .buz(buz_a), .busy(busy_a), .done(done_a));
  buzzer_seq #(.NCH(2), .PLEN(8), .SLOT_CMAX(3), .PATS(TB_PATS), .LENS(TB_LENS), .MODE(1))
    dut_b (.clk(clk), .rst(rst), .tr(tr), .stop(stop), .buz(buz_b), .busy(busy_b), .done(done_b));
  buzzer_seq #(.NCH(2), .PLEN(8), .SLOT_CMAX(1), .PATS(TB_PATS), .LENS(TB_LENS), .MODE(0))
    dut_c (.clk(clk), .rst(rst), .tr(tr), .stop(stop), .buz(buz_c), .busy(busy_c), .done(done_c));

  function automatic logic in_r(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  function automatic logic [4:0] observed(input int sel);
    case (sel)
      0:       return {buz_a, busy_a, done_a};
      1:       return {buz_b, busy_b, done_b};
      default: return {buz_c, busy_c, done_c};
    endcase
  endfunction

  task automatic check(input string tag, input int c, input logic [4:0] obs, input logic [4:0] exp_w);
    total++;
    assert (obs === exp_w) passed++;
    else $error("FAIL %s cyc %0d: observed {buz,busy,done}=%b expected %b", tag, c, obs, exp_w);
  endtask

  // Pulse reset, then check every instance is quiet in the following cycle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tr = 2'b00;
    stop = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) check($sformatf("reset_dut%0d", s), 0, observed(s), 5'b0);
  endtask

  // Cycle 0 is the edge that samples the first stimulus; cycle c is the period after edge c-1.
  task automatic run(input string tag, input int sel, input int ncyc,
                     input int ta_c, input logic [1:0] ta_m,
                     input int tb_c, input logic [1:0] tb_m,
                     input int st_c, input logic [1:0] st_m,
                     input int rst_c);
    logic [4:0] e;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          check({tag, "_queue_empty"}, c, observed(sel), 5'bxxxxx);
        end else begin
          e = exp_q.pop_front();
          check(tag, c, observed(sel), e);
        end
      end
      tr   = ((c == ta_c) ? ta_m : 2'b00) | ((c == tb_c) ? tb_m : 2'b00);
      stop = (c == st_c) ? st_m : 2'b00;
      rst  = (c == rst_c);
    end
    @(negedge clk);
    tr = 2'b00;
    stop = 2'b00;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    do_reset();

    // ch0 alone at a randomised start cycle
    t0 = $urandom_range(3, 10);
    for (int c = 1; c <= t0 + 10; c++)
      exp_q.push_back({in_r(c, t0 + 4, t0 + 6), 1'b0, in_r(c, t0 + 1, t0 + 6), 1'b0, c == t0 + 7});
    run("ch0_single", 0, t0 + 10, t0, 2'b01, -1, 2'b00, -1, 2'b00, -1);

    do_reset();
    for (int c = 1; c <= 22; c++)
      exp_q.push_back({in_r(c, 1, 3) | in_r(c, 7, 9) | in_r(c, 13, 15), in_r(c, 1, 18), 1'b0, c == 19, 1'b0});
    run("ch1_single", 0, 22, 0, 2'b10, -1, 2'b00, -1, 2'b00, -1);

    do_reset();
    for (int c = 1; c <= 28; c++)
      exp_q.push_back({in_r(c, 1, 3) | in_r(c, 6, 8) | in_r(c, 12, 14) | in_r(c, 18, 20),
                       in_r(c, 1, 23), 1'b0, c == 24, 1'b0});
    run("ch1_retrigger", 0, 28, 0, 2'b10, 5, 2'b10, -1, 2'b00, -1);

    do_reset();
    for (int c = 1; c <= 20; c++)
      exp_q.push_back({in_r(c, 1, 3) | in_r(c, 7, 8), in_r(c, 1, 8), 1'b0, 2'b00});
    run("ch1_cancel", 0, 20, 0, 2'b10, -1, 2'b00, 8, 2'b10, -1);

    do_reset();
    for (int c = 1; c <= 22; c++)
      exp_q.push_back({in_r(c, 1, 3) | in_r(c, 7, 9) | in_r(c, 13, 15), in_r(c, 1, 18), 1'b0, c == 19, 1'b0});
    run("ch1_tr_and_stop", 0, 22, 0, 2'b10, -1, 2'b00, 0, 2'b10, -1);

    do_reset();
    for (int c = 1; c <= 22; c++)
      exp_q.push_back({in_r(c, 1, 9) | in_r(c, 13, 15), in_r(c, 1, 18), in_r(c, 1, 6), c == 19, c == 7});
    run("both_or_mode", 0, 22, 0, 2'b11, -1, 2'b00, -1, 2'b00, -1);

    do_reset();
    for (int c = 1; c <= 22; c++)
      exp_q.push_back({in_r(c, 4, 9) | in_r(c, 13, 15), in_r(c, 1, 18), in_r(c, 1, 6), c == 19, c == 7});
    run("both_prio_mode", 1, 22, 0, 2'b11, -1, 2'b00, -1, 2'b00, -1);

    do_reset();
    for (int c = 1; c <= 12; c++)
      exp_q.push_back({in_r(c, 1, 3), in_r(c, 1, 5), 1'b0, 2'b00});
    run("ch1_reset_mid", 0, 12, 0, 2'b10, -1, 2'b00, -1, 2'b00, 5);

    do_reset();
    for (int c = 1; c <= 10; c++)
      exp_q.push_back({(c == 1) || (c == 3) || (c == 5), in_r(c, 1, 6), 1'b0, c == 7, 1'b0});
    run("ch1_fast_slot", 2, 10, 0, 2'b10, -1, 2'b00, -1, 2'b00, -1);

    total++;
    assert (exp_q.size() == 0) passed++;
    else $error("FAIL queue_drained: observed %0d leftover expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
